ptw_arbiter: RTL and testbench
==============================

Name: ptw_arbiter

Overview:
- Shares one page-table-walk memory port between the instruction-side MMU and the data-side MMU.
- Each requester uses the MMU PTW handshake: the request is held high until a one-cycle ack, and read data is valid with the ack.
- The block picks a winner with round-robin priority and latches that requester's address for the whole transaction.
- It routes the response back to the winner, drops responses on flush, and answers with an error if the memory never acks.

Parameters:
- TIMEOUT_CYCLES, 256: number of BUSY cycles without mem_ack before an error response is returned; 0 disables the timeout.
- CNT_W, 9: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_ptw_req  in  1  instruction MMU request
- i_ptw_addr  in  32  instruction MMU PTE address
- i_ptw_data  out  32  read data to instruction MMU
- i_ptw_ack  out  1  response strobe to instruction MMU
- i_ptw_err  out  1  timeout error; valid only with i_ptw_ack
- d_ptw_req  in  1  data MMU request
- d_ptw_addr  in  32  data MMU PTE address
- d_ptw_data  out  32  read data to data MMU
- d_ptw_ack  out  1  response strobe to data MMU
- d_ptw_err  out  1  timeout error; valid only with d_ptw_ack
- flush  in  1  sfence.vma or trap; discards any outstanding walk response
- mem_req  out  1  memory read request
- mem_addr  out  32  memory address
- mem_rdata  in  32  memory read data
- mem_ack  in  1  memory response strobe, at least 1 cycle after mem_req
- busy  out  1  high when the state is not IDLE

Behaviour:
- Single clock domain clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - State IDLE, last_grant = D (so I wins the first tie).
  - Counter 0, mem_req 0, mem_addr 0, busy 0.
  - All *_ack and *_err are 0; *_data are 0.
- Reset wins over all other inputs in the same cycle. A walk in progress at reset is abandoned, and a late mem_ack after reset is ignored because the state is IDLE.
- States:
  - IDLE: no transaction.
  - BUSY: mem_req asserted, waiting for mem_ack.
  - DRAIN: mem_req asserted, response will be discarded.
- IDLE:
  - If flush=0 and at least one request is high, grant one requester.
  - Only one request high: that requester wins.
  - Both high: the requester that is not last_grant wins.
  - On grant: latch the winner's address into mem_addr, record owner, set last_grant = owner, clear the counter, go to BUSY.
  - Requests are ignored in IDLE while flush=1.
  - No combinational path exists from a request to mem_req. The first mem_req appears in the cycle after the request is sampled.
- BUSY:
  - mem_req=1, and mem_addr stays stable.
  - The counter increments every cycle.
  - If mem_ack=1 and flush=0: in the same cycle, drive owner_ack=1 and owner_data=mem_rdata combinationally, then go to IDLE.
  - If mem_ack=1 and flush=1: no ack to either requester; go to IDLE.
  - If mem_ack=0 and flush=1: go to DRAIN.
  - If mem_ack=0, flush=0, TIMEOUT_CYCLES≠0 and counter == TIMEOUT_CYCLES-1: drive owner_ack=1, owner_err=1 and owner_data=0, then go to DRAIN.
- DRAIN:
  - mem_req=1 with the same mem_addr, because a bus read cannot be cancelled.
  - Both acks stay 0.
  - On mem_ack, go to IDLE. The timeout counter is frozen in DRAIN.
- The non-owner's ack, err and data outputs are 0 in every cycle.
- At most one of i_ptw_ack and d_ptw_ack is high in any cycle.
- Back-to-back operation: the cycle after an ack returns to IDLE, and a new request (for example an MMU level-2 request) can be granted in that IDLE cycle. Minimum PTW latency is request sampled at cycle t, mem_req from t+1, ack at the earliest t+2.
- Fairness: with both requesters continuously requesting, grants alternate I, D, I, D.
- Owner rules:
  - A requester that drops its request while it owns the port does not abort the transaction. Its response is still delivered.
  - A requester that changes its address while it owns the port has no effect, because mem_addr is latched.

Decomposition:
- Shared package (defines.sv):
  - ptw_arb_state_t enum {IDLE, BUSY, DRAIN}.
  - ptw_owner_t enum {OWN_I, OWN_D}.
  - PTW_TIMEOUT_DEFAULT constant.
- Sub-module rr_arbiter2: a combinational two-input round-robin picker.
  - Inputs: req[1:0], last.
  - Output: one-hot grant.
  - It is reusable for the later L1 I$/D$ bus arbiter.
- The timeout counter and state machine stay in ptw_arbiter.

Test Plan:
1. Reset, then d_ptw_req=1 with addr 0x8000_1004 → mem_req rises the next cycle with mem_addr 0x8000_1004. mem_ack occurs 3 cycles later with rdata 0x2000_0C01 → d_ptw_ack=1 and d_ptw_data=0x2000_0C01 that cycle, i_ptw_ack=0 throughout.
2. I and D both request continuously, with acks at fixed 2-cycle latency → grant order I, D, I, D. Every mem_addr matches the owner's address at grant, and there are no double acks.
3. Owner I at addr 0x8000_2000; the requester changes i_ptw_addr to 0xDEAD_BEEF mid-BUSY → mem_addr stays 0x8000_2000.
4. flush pulsed while BUSY with no ack → state DRAIN and mem_req stays 1. mem_ack 5 cycles later → no requester ack, back to IDLE, busy=0.
5. TIMEOUT_CYCLES=8 and memory never acks → the owner sees ack=1 and err=1 on the 8th BUSY cycle, then state DRAIN. A later mem_ack returns to IDLE with no further ack.
6. rst asserted mid-BUSY → the next cycle shows mem_req=0, busy=0 and all acks 0. A mem_ack arriving after reset produces no ack.

Source files
------------

// File: rtl/ptw_arbiter_pkg.sv
// ptw_arbiter_pkg
// Shared types and defaults for the page-table-walk port arbiter.
//   ptw_arb_state_t : arbiter FSM states (IDLE / BUSY / DRAIN)
//   ptw_owner_t     : which MMU currently owns the memory port
//   PTW_TIMEOUT_DEFAULT, PTW_CNT_W_DEFAULT : default timeout settings
package ptw_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no transaction
        BUSY  = 2'd1,   // read outstanding, response goes to owner
        DRAIN = 2'd2    // read outstanding, response will be discarded
    } ptw_arb_state_t;

    // Encoding matches the rr_arbiter2 grant bit index (0 = I, 1 = D).
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } ptw_owner_t;

    localparam int PTW_TIMEOUT_DEFAULT = 256;
    localparam int PTW_CNT_W_DEFAULT   = 9;

endpackage

// File: rtl/ptw_arbiter_rr_arbiter2.sv
// rr_arbiter2
// Combinational two-input round-robin picker, reusable for any 2:1 arbiter.
//   req[1:0]   in  : request lines, bit index = requester id
//   last       in  : id of the previous winner (loses a tie)
//   grant[1:0] out : one-hot grant, all zero when nothing requests
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie: the requester that did not win last time goes first.
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ptw_arbiter.sv
// ptw_arbiter
// Shares one page-table-walk memory read port between the instruction MMU
// (i_*) and the data MMU (d_*). Round-robin grant, address latched for the
// whole transaction, response routed to the owner, responses discarded on
// flush, and an error response if the memory does not ack in time.
//   clk, rst                 : clock, synchronous active-high reset
//   i_ptw_req/addr           : instruction MMU request (held until ack)
//   i_ptw_data/ack/err       : response to instruction MMU
//   d_ptw_req/addr           : data MMU request (held until ack)
//   d_ptw_data/ack/err       : response to data MMU
//   flush                    : discard any outstanding walk response
//   mem_req/addr             : memory read request (registered)
//   mem_rdata/ack            : memory response
//   busy                     : arbiter not IDLE
module ptw_arbiter
    import ptw_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = PTW_TIMEOUT_DEFAULT,
    parameter int CNT_W          = PTW_CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ptw_req,
    input  logic [31:0] i_ptw_addr,
    output logic [31:0] i_ptw_data,
    output logic        i_ptw_ack,
    output logic        i_ptw_err,
    input  logic        d_ptw_req,
    input  logic [31:0] d_ptw_addr,
    output logic [31:0] d_ptw_data,
    output logic        d_ptw_ack,
    output logic        d_ptw_err,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    ptw_arb_state_t    state_reg, state_next;
    ptw_owner_t        owner_reg, owner_next;
    ptw_owner_t        last_grant_reg, last_grant_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [31:0]       mem_addr_reg, mem_addr_next;

    logic [1:0]        grant;
    logic              timeout_hit;
    logic              resp_ack;
    logic              resp_err;
    logic [31:0]       resp_data;

    rr_arbiter2 u_rr (
        .req   ({d_ptw_req, i_ptw_req}),
        .last  (last_grant_reg == OWN_D),
        .grant (grant)
    );

    // Counter holds (number of BUSY cycles so far - 1), so this fires on
    // the TIMEOUT_CYCLES-th BUSY cycle.
    assign timeout_hit = TIMEOUT_EN && (cnt_reg == TIMEOUT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_I;
            last_grant_reg <= OWN_D;
            cnt_reg        <= '0;
            mem_addr_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            mem_addr_reg   <= mem_addr_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        mem_addr_next   = mem_addr_reg;
        case (state_reg)
            IDLE: begin
                if (!flush && (grant != 2'b00)) begin
                    state_next      = BUSY;
                    owner_next      = grant[1] ? OWN_D : OWN_I;
                    last_grant_next = grant[1] ? OWN_D : OWN_I;
                    cnt_next        = '0;
                    mem_addr_next   = grant[1] ? d_ptw_addr : i_ptw_addr;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg + 1'b1;
                if (mem_ack) begin
                    state_next = IDLE;
                end else if (flush || timeout_hit) begin
                    // The bus read cannot be cancelled; wait it out.
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: response is combinational from mem_ack so the MMU sees
    // the data in the same cycle the memory delivers it.
    always_comb begin
        resp_ack  = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        if (!rst && (state_reg == BUSY) && !flush) begin
            if (mem_ack) begin
                resp_ack  = 1'b1;
                resp_data = mem_rdata;
            end else if (timeout_hit) begin
                resp_ack  = 1'b1;
                resp_err  = 1'b1;
            end
        end
    end

    assign i_ptw_ack  = resp_ack && (owner_reg == OWN_I);
    assign i_ptw_err  = resp_err && (owner_reg == OWN_I);
    assign i_ptw_data = (owner_reg == OWN_I) ? resp_data : '0;
    assign d_ptw_ack  = resp_ack && (owner_reg == OWN_D);
    assign d_ptw_err  = resp_err && (owner_reg == OWN_D);
    assign d_ptw_data = (owner_reg == OWN_D) ? resp_data : '0;

    assign mem_req  = (state_reg != IDLE);
    assign busy     = (state_reg != IDLE);
    assign mem_addr = mem_addr_reg;

endmodule

// File: tb/tb_ptw_arbiter.sv
// tb_ptw_arbiter
// Scoreboard bench for ptw_arbiter (built with an 8-cycle timeout).
// Stimulus pushes expected grant addresses and expected MMU responses into
// queues; a monitor branch pops and compares whenever mem_req rises or an
// MMU ack is presented.
module tb_ptw_arbiter;

    typedef struct {
        bit          port;   // 0 = I, 1 = D
        logic [31:0] data;
        bit          err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ptw_req, d_ptw_req;
    logic [31:0] i_ptw_addr, d_ptw_addr;
    logic [31:0] i_ptw_data, d_ptw_data;
    logic        i_ptw_ack, i_ptw_err, d_ptw_ack, d_ptw_err;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    resp_t       exp_resp[$];
    logic [31:0] exp_addr[$];

    ptw_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_ptw_req  (i_ptw_req),
        .i_ptw_addr (i_ptw_addr),
        .i_ptw_data (i_ptw_data),
        .i_ptw_ack  (i_ptw_ack),
        .i_ptw_err  (i_ptw_err),
        .d_ptw_req  (d_ptw_req),
        .d_ptw_addr (d_ptw_addr),
        .d_ptw_data (d_ptw_data),
        .d_ptw_ack  (d_ptw_ack),
        .d_ptw_err  (d_ptw_err),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_resp(input bit port, input logic [31:0] data, input bit err);
        resp_t r;
        r.port = port;
        r.data = data;
        r.err  = err;
        exp_resp.push_back(r);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_acks"}, {30'd0, i_ptw_ack, d_ptw_ack}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; i_ptw_req = 1'b0; d_ptw_req = 1'b0;
        i_ptw_addr = '0; d_ptw_addr = '0; flush = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0;

        fork
            // ---------------- stimulus ----------------
            begin
                repeat (3) tick();
                rst = 1'b0;
                tick();
                chk_idle_outputs("reset");
                chk("reset_mem_addr", mem_addr, 32'h0);
                chk("reset_data", i_ptw_data | d_ptw_data, 32'h0);

                // 1: single D walk, ack on 4th BUSY cycle
                d_ptw_req = 1'b1; d_ptw_addr = 32'h8000_1004;
                exp_addr.push_back(32'h8000_1004);
                tick();
                chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
                repeat (3) tick();
                mem_ack = 1'b1; mem_rdata = 32'h2000_0C01;
                push_resp(1'b1, 32'h2000_0C01, 1'b0);
                tick();
                mem_ack = 1'b0; d_ptw_req = 1'b0;
                $display("txn t1 single D walk done");

                // 2: both requesting continuously, alternate I, D, I, D
                i_ptw_req = 1'b1; i_ptw_addr = 32'h8000_3000;
                d_ptw_req = 1'b1; d_ptw_addr = 32'h8000_4000;
                for (int k = 0; k < 4; k++) begin
                    exp_addr.push_back((k % 2 == 0) ? 32'h8000_3000 : 32'h8000_4000);
                    tick();
                    tick();
                    mem_ack = 1'b1; mem_rdata = 32'h1000_0000 + k;
                    push_resp(k % 2 == 1, 32'h1000_0000 + k, 1'b0);
                    tick();
                    mem_ack = 1'b0;
                    $display("txn t2 round-robin grant %0d done", k);
                end
                i_ptw_req = 1'b0; d_ptw_req = 1'b0;
                tick();

                // 3: owner I changes its address and drops req mid-BUSY
                i_ptw_req = 1'b1; i_ptw_addr = 32'h8000_2000;
                exp_addr.push_back(32'h8000_2000);
                tick();
                i_ptw_addr = 32'hDEAD_BEEF; i_ptw_req = 1'b0;
                tick();
                chk("t3_addr_stable", mem_addr, 32'h8000_2000);
                mem_ack = 1'b1; mem_rdata = 32'h0000_00C7;
                push_resp(1'b0, 32'h0000_00C7, 1'b0);
                tick();
                mem_ack = 1'b0;
                $display("txn t3 address latch done");

                // Requests ignored in IDLE while flush is high
                i_ptw_req = 1'b1; i_ptw_addr = 32'h8000_6000; flush = 1'b1;
                tick();
                chk("idle_flush_busy", {31'd0, busy}, 32'd0);
                flush = 1'b0;
                exp_addr.push_back(32'h8000_6000);
                tick();
                chk("idle_flush_grant", {31'd0, busy}, 32'd1);
                i_ptw_req = 1'b0;
                // mem_ack together with flush: dropped, back to IDLE
                mem_ack = 1'b1; flush = 1'b1; mem_rdata = 32'h5555_AAAA;
                @(negedge clk);
                chk("ackflush_acks", {30'd0, i_ptw_ack, d_ptw_ack}, 32'd0);
                tick();
                mem_ack = 1'b0; flush = 1'b0;
                chk_idle_outputs("ackflush");
                $display("txn flush-in-idle and ack-with-flush done");

                // 4: flush while BUSY without ack -> DRAIN
                d_ptw_req = 1'b1; d_ptw_addr = 32'h8000_7008;
                exp_addr.push_back(32'h8000_7008);
                tick();
                d_ptw_req = 1'b0;
                tick();
                flush = 1'b1;
                tick();
                flush = 1'b0;
                chk("t4_drain_mem_req", {31'd0, mem_req}, 32'd1);
                chk("t4_drain_busy", {31'd0, busy}, 32'd1);
                chk("t4_drain_addr", mem_addr, 32'h8000_7008);
                repeat (4) tick();
                mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
                @(negedge clk);
                chk("t4_drain_acks", {30'd0, i_ptw_ack, d_ptw_ack}, 32'd0);
                tick();
                mem_ack = 1'b0;
                chk_idle_outputs("t4_end");
                $display("txn t4 flush drain done");

                // 5: no memory ack -> error response on 8th BUSY cycle
                i_ptw_req = 1'b1; i_ptw_addr = 32'h8000_5000;
                mem_rdata = 32'h1234_5678;
                exp_addr.push_back(32'h8000_5000);
                push_resp(1'b0, 32'h0, 1'b1);
                tick();
                i_ptw_req = 1'b0;
                repeat (7) tick();
                chk("t5_timeout_ack", {31'd0, i_ptw_ack}, 32'd1);
                tick();
                chk("t5_drain_busy", {31'd0, busy}, 32'd1);
                chk("t5_drain_no_ack", {31'd0, i_ptw_ack}, 32'd0);
                repeat (3) tick();
                mem_ack = 1'b1;
                tick();
                mem_ack = 1'b0;
                chk_idle_outputs("t5_end");
                $display("txn t5 timeout done");

                // 6: reset mid-BUSY, late mem_ack ignored
                d_ptw_req = 1'b1; d_ptw_addr = 32'h8000_9000;
                exp_addr.push_back(32'h8000_9000);
                tick();
                d_ptw_req = 1'b0;
                tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk_idle_outputs("t6_after_rst");
                chk("t6_mem_addr", mem_addr, 32'h0);
                mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
                tick();
                mem_ack = 1'b0;
                chk_idle_outputs("t6_late_ack");
                // last_grant is D again after reset, so I wins the tie
                i_ptw_req = 1'b1; i_ptw_addr = 32'h8000_A000;
                d_ptw_req = 1'b1; d_ptw_addr = 32'h8000_B000;
                exp_addr.push_back(32'h8000_A000);
                tick();
                i_ptw_req = 1'b0; d_ptw_req = 1'b0;
                tick();
                mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
                push_resp(1'b0, 32'hCAFE_0001, 1'b0);
                tick();
                mem_ack = 1'b0;
                $display("txn t6 reset mid-walk done");
                repeat (3) tick();
            end
            // ---------------- monitor ----------------
            begin
                resp_t r;
                logic  prev_req;
                bit          got_port;
                logic [31:0] got_data, oth_data;
                logic        got_err, oth_err;
                prev_req = 1'b0;
                forever begin
                    @(negedge clk);
                    if (i_ptw_ack === 1'b1 || d_ptw_ack === 1'b1) begin
                        checks++;
                        if (i_ptw_ack === 1'b1 && d_ptw_ack === 1'b1) begin
                            failures++;
                            $display("FAIL double_ack actual=both required=one");
                        end else if (exp_resp.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_ack actual=i%0b/d%0b required=none",
                                     i_ptw_ack, d_ptw_ack);
                        end else begin
                            r        = exp_resp.pop_front();
                            got_port = (d_ptw_ack === 1'b1);
                            got_data = got_port ? d_ptw_data : i_ptw_data;
                            got_err  = got_port ? d_ptw_err : i_ptw_err;
                            oth_data = got_port ? i_ptw_data : d_ptw_data;
                            oth_err  = got_port ? i_ptw_err : d_ptw_err;
                            if (got_port != r.port || got_data !== r.data ||
                                got_err !== r.err || oth_data !== 32'h0 || oth_err !== 1'b0) begin
                                failures++;
                                $display("FAIL resp actual=port%0b data=%h err=%0b other=%h/%0b required=port%0b data=%h err=%0b other=0/0",
                                         got_port, got_data, got_err, oth_data, oth_err,
                                         r.port, r.data, r.err);
                            end else begin
                                $display("resp ok port=%0b data=%h err=%0b", got_port, got_data, got_err);
                            end
                        end
                    end
                    if ((i_ptw_err === 1'b1 && i_ptw_ack !== 1'b1) ||
                        (d_ptw_err === 1'b1 && d_ptw_ack !== 1'b1)) begin
                        checks++;
                        failures++;
                        $display("FAIL stray_err actual=i%0b/d%0b required=0", i_ptw_err, d_ptw_err);
                    end
                    if (mem_req === 1'b1 && prev_req !== 1'b1) begin
                        checks++;
                        if (exp_addr.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_grant actual=%h required=none", mem_addr);
                        end else begin
                            r.data = exp_addr.pop_front();
                            if (mem_addr !== r.data) begin
                                failures++;
                                $display("FAIL grant_addr actual=%h required=%h", mem_addr, r.data);
                            end else begin
                                $display("grant ok addr=%h", mem_addr);
                            end
                        end
                    end
                    prev_req = mem_req;
                end
            end
        join_any

        chk("left_resp", exp_resp.size(), 32'd0);
        chk("left_grant", exp_addr.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
